ballot_booth_arbiter: RTL and testbench

BALLOT_BOOTH_ARBITER -- requirements
Module: ballot_booth_arbiter

---
 rtl/ballot_booth_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ballot_booth_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_booth_arbiter.sv
// Four-booth round-robin arbiter sharing one EVM: grants a booth, prompts the EVM,
// forwards a single clean button press or abandons the booth after TIMEOUT cycles.
module ballot_booth_arbiter #(
    parameter int unsigned TIMEOUT = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evm_enable,
    input  logic [3:0]  booth_req,
    input  logic [11:0] booth_vote,
    output logic [3:0]  booth_grant,
    output logic        evm_candidate_ready,
    output logic [2:0]  evm_vote,
    output logic [3:0]  booth_done,
    output logic [3:0]  booth_timeout,
    output logic        busy
);

    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_READY,
        S_VOTE_WAIT,
        S_FWD,
        S_RELEASE
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    gidx, gidx_nxt;
    logic [1:0]    last_grant, last_grant_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    vote_reg, vote_reg_nxt;

    logic [3:0]    grant_nxt, done_nxt, timeout_nxt;
    logic [2:0]    evm_vote_nxt;
    logic          ready_nxt, busy_nxt;

    logic [1:0]    pick, cand;
    logic          pick_ok;
    logic [2:0]    sel_vote;
    logic          vote_valid, timer_last, timed_out;

    // Round-robin search starting one past the last served booth; lowest offset wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + 2'(k);
            if (booth_req[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        case (gidx)
            2'd0:    sel_vote = booth_vote[2:0];
            2'd1:    sel_vote = booth_vote[5:3];
            2'd2:    sel_vote = booth_vote[8:6];
            default: sel_vote = booth_vote[11:9];
        endcase
    end

    assign vote_valid = (sel_vote == 3'b001) || (sel_vote == 3'b010) || (sel_vote == 3'b100);
    assign timer_last = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        gidx_nxt       = gidx;
        last_grant_nxt = last_grant;
        timer_nxt      = timer;
        vote_reg_nxt   = vote_reg;
        timed_out      = 1'b0;

        case (state)
            S_IDLE: begin
                if (evm_enable && (booth_req != 4'b0000)) state_nxt = S_ARB;
            end
            S_ARB: begin
                if (pick_ok) begin
                    gidx_nxt  = pick;
                    state_nxt = S_READY;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_READY: begin
                timer_nxt = '0;
                state_nxt = S_VOTE_WAIT;
            end
            S_VOTE_WAIT: begin
                // A voter walking away beats a press; a press beats the timeout.
                if (!booth_req[gidx]) begin
                    state_nxt = S_RELEASE;
                end else if (vote_valid) begin
                    vote_reg_nxt = sel_vote;
                    state_nxt    = S_FWD;
                end else if (timer_last) begin
                    timed_out = 1'b1;
                    state_nxt = S_RELEASE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_FWD: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                last_grant_nxt = gidx;
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (!evm_enable) begin
            state_nxt      = S_IDLE;
            timer_nxt      = '0;
            timed_out      = 1'b0;
            last_grant_nxt = last_grant;
        end

        // Outputs are decoded from the state being entered so they register alongside it.
        busy_nxt     = (state_nxt != S_IDLE);
        ready_nxt    = (state_nxt == S_READY);
        grant_nxt    = ((state_nxt == S_READY) || (state_nxt == S_VOTE_WAIT) || (state_nxt == S_FWD))
                       ? (4'b0001 << gidx_nxt) : 4'b0000;
        evm_vote_nxt = (state_nxt == S_FWD) ? vote_reg_nxt : 3'b000;
        done_nxt     = (state_nxt == S_FWD) ? (4'b0001 << gidx_nxt) : 4'b0000;
        timeout_nxt  = timed_out ? (4'b0001 << gidx) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= S_IDLE;
            gidx                <= '0;
            last_grant          <= 2'd3;
            timer               <= '0;
            vote_reg            <= '0;
            booth_grant         <= '0;
            evm_candidate_ready <= 1'b0;
            evm_vote            <= '0;
            booth_done          <= '0;
            booth_timeout       <= '0;
            busy                <= 1'b0;
        end else begin
            state               <= state_nxt;
            gidx                <= gidx_nxt;
            last_grant          <= last_grant_nxt;
            timer               <= timer_nxt;
            vote_reg            <= vote_reg_nxt;
            booth_grant         <= grant_nxt;
            evm_candidate_ready <= ready_nxt;
            evm_vote            <= evm_vote_nxt;
            booth_done          <= done_nxt;
            booth_timeout       <= timeout_nxt;
            busy                <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ballot_booth_arbiter.sv
// Bench for ballot_booth_arbiter: transaction-age reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ballot_booth_arbiter;

    localparam int unsigned TO = 10;

    logic        clk;
    logic        rst;
    logic        evm_enable;
    logic [3:0]  booth_req;
    logic [11:0] booth_vote;
    logic [3:0]  booth_grant;
    logic        evm_candidate_ready;
    logic [2:0]  evm_vote;
    logic [3:0]  booth_done;
    logic [3:0]  booth_timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    ballot_booth_arbiter #(.TIMEOUT(TO)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .evm_enable          (evm_enable),
        .booth_req           (booth_req),
        .booth_vote          (booth_vote),
        .booth_grant         (booth_grant),
        .evm_candidate_ready (evm_candidate_ready),
        .evm_vote            (evm_vote),
        .booth_done          (booth_done),
        .booth_timeout       (booth_timeout),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] hot(input int i);
        return 4'(1 << i);
    endfunction

    // Reference model: age counts edges since the request was accepted (-1 = idle);
    // age 0 is arbitration, 1 the prompt cycle, 2.. the voting window.
    int         m_age   = -1;
    int         m_owner = 0;
    int         m_last  = 3;
    logic [2:0] m_vreg  = '0;
    logic       m_fwd   = 1'b0;
    logic       m_rel   = 1'b0;
    logic [3:0] e_to    = '0;

    task automatic mdl_reset();
        m_age  = -1;
        m_fwd  = 1'b0;
        m_rel  = 1'b0;
        m_last = 3;
        m_vreg = '0;
        e_to   = '0;
    endtask

    task automatic mdl_step(input logic en, input logic [3:0] req, input logic [11:0] vote);
        logic [2:0] bits;
        logic [3:0] sh;
        e_to = '0;
        if (!en) begin
            m_age = -1;
            m_fwd = 1'b0;
            m_rel = 1'b0;
        end else if (m_rel) begin
            m_last = m_owner;
            m_rel  = 1'b0;
            m_age  = -1;
        end else if (m_fwd) begin
            m_fwd = 1'b0;
            m_rel = 1'b1;
        end else if (m_age == -1) begin
            if (req != 4'b0000) m_age = 0;
        end else if (m_age == 0) begin
            if (req == 4'b0000) begin
                m_age = -1;
            end else begin
                for (int i = 4; i >= 1; i--) begin
                    sh = req >> ((m_last + i) % 4);
                    if (sh[0]) m_owner = (m_last + i) % 4;
                end
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            bits = 3'(vote >> (m_owner * 3));
            sh   = req >> m_owner;
            if (!sh[0]) begin
                m_rel = 1'b1;
            end else if ($countones(bits) == 1) begin
                m_vreg = bits;
                m_fwd  = 1'b1;
            end else if (m_age - 2 == int'(TO) - 1) begin
                e_to  = hot(m_owner);
                m_rel = 1'b1;
            end else begin
                m_age++;
            end
        end
    endtask

    // Every-cycle comparison against the model, sampled 1 time unit after the edge.
    initial begin
        logic [3:0] e_grant, e_done;
        logic [2:0] e_vote;
        logic       e_ready, e_busy;
        forever begin
            @(posedge clk);
            if (!rst) mdl_reset();
            else      mdl_step(evm_enable, booth_req, booth_vote);
            #1;
            e_busy  = (m_age != -1);
            e_grant = (m_age >= 1 && !m_rel) ? hot(m_owner) : 4'b0000;
            e_ready = (m_age == 1);
            e_vote  = m_fwd ? m_vreg : 3'b000;
            e_done  = m_fwd ? hot(m_owner) : 4'b0000;
            check("cyc_grant",   32'(booth_grant),         32'(e_grant));
            check("cyc_ready",   32'(evm_candidate_ready), 32'(e_ready));
            check("cyc_vote",    32'(evm_vote),            32'(e_vote));
            check("cyc_done",    32'(booth_done),          32'(e_done));
            check("cyc_timeout", 32'(booth_timeout),       32'(e_to));
            check("cyc_busy",    32'(busy),                32'(e_busy));
            check("inv_ready_vote_excl", 32'(evm_candidate_ready && (evm_vote != 3'b000)), 32'h0);
            check("inv_grant_onehot0",   32'($countones(booth_grant) <= 1), 32'h1);
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (evm_candidate_ready) break;
        end
        check("ready_seen", 32'(evm_candidate_ready), 32'h1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_seen", 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        int         cnt;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst        = 1'b0;
        evm_enable = 1'b0;
        booth_req  = 4'b0000;
        booth_vote = 12'h000;
        @(negedge clk);
        check("rst_grant", 32'(booth_grant), 32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_ready", 32'(evm_candidate_ready), 32'h0);
        check("rst_vote",  32'(evm_vote),    32'h0);

        // Single voter on booth 0, button 2
        rst        = 1'b1;
        evm_enable = 1'b1;
        booth_req  = 4'b0001;
        @(negedge clk);
        check("t1_first_edge_nogrant", 32'(booth_grant), 32'h0);
        check("t1_arb_busy",           32'(busy),        32'h1);
        @(negedge clk);
        check("t1_ready",      32'(evm_candidate_ready), 32'h1);
        check("t1_grant",      32'(booth_grant),         32'h1);
        @(negedge clk);
        check("t1_ready_once", 32'(evm_candidate_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        booth_vote = 12'b000_000_000_010;
        @(negedge clk);
        check("t1_vote", 32'(evm_vote),   32'h2);
        check("t1_done", 32'(booth_done), 32'h1);
        booth_req  = 4'b0000;
        booth_vote = 12'h000;
        @(negedge clk);
        check("t1_vote_once",    32'(evm_vote),    32'h0);
        check("t1_release_free", 32'(booth_grant), 32'h0);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'h0);

        // Round robin with everyone waiting and nobody pressing
        do_reset();
        booth_req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_ready();
            check("rr_grant", 32'(booth_grant), 32'(rr_exp[t]));
            cnt = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                cnt++;
                if (booth_timeout != 4'b0000) break;
            end
            check("rr_timeout_latency", 32'(cnt),           32'd11);
            check("rr_timeout_booth",   32'(booth_timeout), 32'(rr_exp[t]));
        end
        booth_req = 4'b0000;
        wait_idle();

        // Double press ignored, then clean press; other booths queue meanwhile
        do_reset();
        booth_req = 4'b0010;
        wait_ready();
        check("t3_grant", 32'(booth_grant), 32'h2);
        @(negedge clk);
        booth_vote = 12'b000_000_011_000;
        booth_req  = 4'b1011;
        repeat (2) begin
            @(negedge clk);
            check("t3_double_ignored", 32'(evm_vote),    32'h0);
            check("t3_grant_held",     32'(booth_grant), 32'h2);
        end
        booth_vote = 12'b000_000_100_000;
        @(negedge clk);
        check("t3_vote", 32'(evm_vote),   32'h4);
        check("t3_done", 32'(booth_done), 32'h2);
        booth_vote = 12'h000;
        booth_req  = 4'b1001;
        wait_ready();
        check("t3_next_grant", 32'(booth_grant), 32'h8);
        @(negedge clk);
        booth_req = 4'b0001;
        @(negedge clk);
        check("t3_withdraw_grant",   32'(booth_grant),   32'h0);
        check("t3_withdraw_timeout", 32'(booth_timeout), 32'h0);
        check("t3_withdraw_done",    32'(booth_done),    32'h0);
        @(negedge clk);
        check("t3_withdraw_idle", 32'(busy), 32'h0);
        booth_req = 4'b0000;
        wait_idle();

        // Power-off mid-vote keeps the round-robin pointer
        do_reset();
        booth_req = 4'b0011;
        wait_ready();
        check("t4_grant", 32'(booth_grant), 32'h1);
        @(negedge clk);
        evm_enable = 1'b0;
        @(negedge clk);
        check("t4_off_busy",  32'(busy),        32'h0);
        check("t4_off_grant", 32'(booth_grant), 32'h0);
        evm_enable = 1'b1;
        wait_ready();
        check("t4_regrant", 32'(booth_grant), 32'h1);
        booth_req = 4'b0000;
        wait_idle();

        // Async reset while forwarding a vote
        do_reset();
        booth_req = 4'b0110;
        wait_ready();
        check("t5_grant1", 32'(booth_grant), 32'h2);
        @(negedge clk);
        booth_vote = 12'b000_000_001_000;
        @(negedge clk);
        check("t5_vote1", 32'(evm_vote), 32'h1);
        booth_vote = 12'h000;
        booth_req  = 4'b0101;
        wait_ready();
        check("t5_grant2", 32'(booth_grant), 32'h4);
        @(negedge clk);
        booth_vote = 12'b000_100_000_000;
        @(negedge clk);
        check("t5_vote2", 32'(evm_vote), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_vote",  32'(evm_vote),    32'h0);
        check("t5_async_done",  32'(booth_done),  32'h0);
        check("t5_async_busy",  32'(busy),        32'h0);
        check("t5_async_grant", 32'(booth_grant), 32'h0);
        booth_vote = 12'h000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_ready();
        check("t5_after_reset_grant", 32'(booth_grant), 32'h1);
        booth_req = 4'b0000;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
